// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pattern controller: pattern modes,
// 8-bit colour struct, bar colour table and default 640x480@60 timing.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_DIAG    = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_COLOR_W  = 8;

  localparam rgb_t RGB_WHITE   = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam rgb_t RGB_YELLOW  = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
  localparam rgb_t RGB_CYAN    = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
  localparam rgb_t RGB_GREEN   = '{r: 8'h00, g: 8'hFF, b: 8'h00};
  localparam rgb_t RGB_MAGENTA = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
  localparam rgb_t RGB_RED     = '{r: 8'hFF, g: 8'h00, b: 8'h00};
  localparam rgb_t RGB_BLUE    = '{r: 8'h00, g: 8'h00, b: 8'hFF};
  localparam rgb_t RGB_BLACK   = '{r: 8'h00, g: 8'h00, b: 8'h00};
  localparam rgb_t DIAG_RED    = '{r: 8'h96, g: 8'h00, b: 8'h00};

  // Index 0 is the leftmost bar.
  localparam rgb_t [7:0] BAR_COLORS = {RGB_BLACK, RGB_BLUE, RGB_RED, RGB_MAGENTA,
                                       RGB_GREEN, RGB_CYAN, RGB_YELLOW, RGB_WHITE};

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-enable divider, vga_clk, raster counters and raw sync/active flags.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          clock,
  input  logic          reset,
  output logic          pix_en,
  output logic          frame_tick,
  output logic          vga_clk,
  output logic [XW-1:0] cnt_h,
  output logic [YW-1:0] cnt_v,
  output logic          hs_raw,
  output logic          vs_raw,
  output logic          active_raw
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  logic [DW-1:0] div_cnt;
  logic          pe;
  logic          running;
  logic          h_last;
  logic          v_last;

  assign pe     = (div_cnt == DW'(CLK_DIV - 1));
  assign h_last = (cnt_h == XW'(H_TOTAL - 1));
  assign v_last = (cnt_v == YW'(V_TOTAL - 1));

  // The first pe after reset only starts the frame at (0,0) without advancing.
  assign frame_tick = pe && (!running || (h_last && v_last));
  assign pix_en     = pe && running;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      vga_clk <= 1'b0;
    end else begin
      div_cnt <= pe ? '0 : div_cnt + DW'(1);
      vga_clk <= (div_cnt >= DW'(CLK_DIV / 2));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      running <= 1'b0;
      cnt_h   <= '0;
      cnt_v   <= '0;
    end else if (pe) begin
      running <= 1'b1;
      if (running) begin
        if (h_last) begin
          cnt_h <= '0;
          cnt_v <= v_last ? '0 : cnt_v + YW'(1);
        end else begin
          cnt_h <= cnt_h + XW'(1);
        end
      end
    end
  end

  assign hs_raw     = (cnt_h >= XW'(H_ACTIVE + H_FP)) && (cnt_h < XW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_raw     = (cnt_v >= YW'(V_ACTIVE + V_FP)) && (cnt_v < YW'(V_ACTIVE + V_FP + V_SYNC));
  assign active_raw = (cnt_h < XW'(H_ACTIVE)) && (cnt_v < YW'(V_ACTIVE));

endmodule

// File: rtl/vga_pattern_ctrl.sv
// VGA timing + four-mode test-pattern generator driving an ADV7123-style DAC.
// Define VGA_BORDER_EN to force the outermost active pixels to white.
module vga_pattern_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  localparam int XW      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  localparam int YW      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           mode_i,
  input  logic [3*COLOR_W-1:0] solid_rgb_i,
  output logic                 vga_clk,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blank,
  output logic                 syncn,
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b,
  output logic [XW-1:0]        pix_x,
  output logic [YW-1:0]        pix_y,
  output logic                 frame_start
);

  localparam int CW    = (XW > YW) ? XW : YW;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int NB    = (COLOR_W < 8) ? COLOR_W : 8;

  logic                 pix_en;
  logic                 frame_tick;
  logic                 hs_raw;
  logic                 vs_raw;
  logic                 active_raw;
  logic [XW-1:0]        cnt_h;
  logic [YW-1:0]        cnt_v;
  logic [2:0]           bar_idx;
  mode_e                mode_q;
  logic [3*COLOR_W-1:0] solid_q;
  rgb_t                 pat8;
  logic [COLOR_W-1:0]   r_n;
  logic [COLOR_W-1:0]   g_n;
  logic [COLOR_W-1:0]   b_n;

  // MSB-align an 8-bit channel into COLOR_W bits.
  function automatic logic [COLOR_W-1:0] widen(input logic [7:0] v);
    logic [COLOR_W-1:0] o;
    o = '0;
    for (int i = 0; i < NB; i++) o[COLOR_W-1-i] = v[7-i];
    return o;
  endfunction

  vga_sync_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .XW(XW), .YW(YW)
  ) u_sync (
    .clock(clock), .reset(reset), .pix_en(pix_en), .frame_tick(frame_tick),
    .vga_clk(vga_clk), .cnt_h(cnt_h), .cnt_v(cnt_v),
    .hs_raw(hs_raw), .vs_raw(vs_raw), .active_raw(active_raw)
  );

  assign bar_idx = 3'(cnt_h / XW'(BAR_W));
  assign syncn   = 1'b0;

  // Pattern inputs only change at frame boundaries so a frame never tears.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q  <= MODE_DIAG;
      solid_q <= '0;
    end else if (frame_tick) begin
      mode_q  <= mode_e'(mode_i);
      solid_q <= solid_rgb_i;
    end
  end

  always_comb begin
    pat8 = RGB_BLACK;
    case (mode_q)
      MODE_DIAG:    pat8 = (CW'(cnt_h) > CW'(cnt_v)) ? DIAG_RED : RGB_WHITE;
      MODE_BARS:    pat8 = BAR_COLORS[bar_idx];
      MODE_CHECKER: pat8 = (cnt_h[5] ^ cnt_v[5]) ? RGB_WHITE : RGB_BLACK;
      default:      pat8 = RGB_BLACK;
    endcase
    r_n = widen(pat8.r);
    g_n = widen(pat8.g);
    b_n = widen(pat8.b);
    if (mode_q == MODE_SOLID) {r_n, g_n, b_n} = solid_q;
`ifdef VGA_BORDER_EN
    if (cnt_h == '0 || cnt_h == XW'(H_ACTIVE - 1) ||
        cnt_v == '0 || cnt_v == YW'(V_ACTIVE - 1)) begin
      r_n = '1;
      g_n = '1;
      b_n = '1;
    end
`else
`endif
    if (!active_raw) begin
      r_n = '0;
      g_n = '0;
      b_n = '0;
    end
  end

  // Everything describing a pixel is captured together, one pixel behind the counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      blank <= 1'b0;
      r     <= '0;
      g     <= '0;
      b     <= '0;
      pix_x <= '0;
      pix_y <= '0;
    end else if (pix_en) begin
      hsync <= hs_raw ? HS_POL : ~HS_POL;
      vsync <= vs_raw ? VS_POL : ~VS_POL;
      blank <= active_raw;
      r     <= r_n;
      g     <= g_n;
      b     <= b_n;
      pix_x <= cnt_h;
      pix_y <= cnt_v;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) frame_start <= 1'b0;
    else        frame_start <= frame_tick;
  end

endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// Directed bench for vga_pattern_ctrl on a reduced 64x36 raster so whole frames fit
// the run; honours VGA_BORDER_EN when expecting border pixels.
module tb_vga_pattern_ctrl;

  localparam int H_ACTIVE   = 64;
  localparam int H_FP       = 2;
  localparam int H_SYNC     = 4;
  localparam int H_BP       = 2;
  localparam int V_ACTIVE   = 36;
  localparam int V_FP       = 1;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 2;
  localparam int CLK_DIV    = 2;
  localparam int COLOR_W    = 8;
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW         = $clog2(H_TOTAL);
  localparam int YW         = $clog2(V_TOTAL);
  localparam int FRAME_CLKS = H_TOTAL * V_TOTAL * CLK_DIV;

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] solid;
    int          x;
    int          y;
    logic [23:0] rgb;
    logic        blank;
  } vec_t;

  logic                 clock;
  logic                 reset;
  logic [1:0]           mode_i;
  logic [3*COLOR_W-1:0] solid_rgb_i;
  logic                 vga_clk;
  logic                 hsync;
  logic                 vsync;
  logic                 blank;
  logic                 syncn;
  logic [COLOR_W-1:0]   r;
  logic [COLOR_W-1:0]   g;
  logic [COLOR_W-1:0]   b;
  logic [XW-1:0]        pix_x;
  logic [YW-1:0]        pix_y;
  logic                 frame_start;

  int   compared;
  int   mismatched;
  vec_t vecs [24];

  vga_pattern_ctrl #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .COLOR_W(COLOR_W), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clock(clock), .reset(reset), .mode_i(mode_i), .solid_rgb_i(solid_rgb_i),
    .vga_clk(vga_clk), .hsync(hsync), .vsync(vsync), .blank(blank), .syncn(syncn),
    .r(r), .g(g), .b(b), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    repeat (90000) @(posedge clock);
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [23:0] solid);
    bit seen;
    mode_i      = mode;
    solid_rgb_i = solid;
    seen        = 1'b0;
    for (int n = 0; n < 2 * FRAME_CLKS; n++) begin
      @(negedge clock);
      if (frame_start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) compare("frame_start.wait", 32'd0, 32'd1);
  endtask

  task automatic checkOutput(input string name, input int x, input int y,
                             input logic [23:0] exp_rgb_in, input logic exp_blank);
    bit          found;
    logic [23:0] exp_rgb;
    logic        exp_hs;
    logic        exp_vs;
    found = 1'b0;
    for (int n = 0; n < 2 * FRAME_CLKS + 4; n++) begin
      @(negedge clock);
      if (int'(pix_x) == x && int'(pix_y) == y) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      compare({name, ".found"}, 32'd0, 32'd1);
      return;
    end
    exp_rgb = exp_rgb_in;
`ifdef VGA_BORDER_EN
    if (exp_blank && (x == 0 || x == H_ACTIVE - 1 || y == 0 || y == V_ACTIVE - 1))
      exp_rgb = 24'hFFFFFF;
`else
`endif
    exp_hs = !(x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC);
    exp_vs = !(y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC);
    compare({name, ".blank"}, 32'(blank), 32'(exp_blank));
    compare({name, ".rgb"}, 32'({r, g, b}), 32'(exp_rgb));
    compare({name, ".sync"}, 32'({hsync, vsync}), 32'({exp_hs, exp_vs}));
  endtask

  task automatic checkResetValues(input string name);
    compare({name, ".flags"}, 32'({hsync, vsync, blank, syncn, vga_clk, frame_start}), 32'b110000);
    compare({name, ".rgb"}, 32'({r, g, b}), 32'd0);
    compare({name, ".pix"}, 32'({pix_x, pix_y}), 32'd0);
  endtask

  task automatic releaseAndCheck(input string name);
    int n;
    n = 0;
    reset = 1'b1;
    for (int k = 1; k <= 4 * CLK_DIV; k++) begin
      @(negedge clock);
      if (frame_start) begin
        n = k;
        break;
      end
    end
    compare({name, ".fs_delay"}, 32'(n), 32'(CLK_DIV));
    compare({name, ".pix"}, 32'({pix_x, pix_y}), 32'd0);
  endtask

  initial begin
    int fs_count, fs_pos, hs_low, vs_low, clk_high, clk_rise, blank_high, syncn_high;
    logic prev_clk;

    compared    = 0;
    mismatched  = 0;
    reset       = 1'b0;
    mode_i      = 2'd0;
    solid_rgb_i = '0;

    vecs[0]  = '{2'd0, 24'h0,       10,  5, 24'h960000, 1'b1};
    vecs[1]  = '{2'd0, 24'h0,        7,  7, 24'hFFFFFF, 1'b1};
    vecs[2]  = '{2'd0, 24'h0,        5, 10, 24'hFFFFFF, 1'b1};
    vecs[3]  = '{2'd0, 24'h0,       66, 20, 24'h000000, 1'b0};
    vecs[4]  = '{2'd0, 24'h0,        3, 37, 24'h000000, 1'b0};
    vecs[5]  = '{2'd1, 24'h0,        0,  3, 24'hFFFFFF, 1'b1};
    vecs[6]  = '{2'd1, 24'h0,        7,  3, 24'hFFFFFF, 1'b1};
    vecs[7]  = '{2'd1, 24'h0,        8,  3, 24'hFFFF00, 1'b1};
    vecs[8]  = '{2'd1, 24'h0,       17,  3, 24'h00FFFF, 1'b1};
    vecs[9]  = '{2'd1, 24'h0,       25,  3, 24'h00FF00, 1'b1};
    vecs[10] = '{2'd1, 24'h0,       33,  3, 24'hFF00FF, 1'b1};
    vecs[11] = '{2'd1, 24'h0,       47,  3, 24'hFF0000, 1'b1};
    vecs[12] = '{2'd1, 24'h0,       48,  3, 24'h0000FF, 1'b1};
    vecs[13] = '{2'd1, 24'h0,       63,  3, 24'h000000, 1'b1};
    vecs[14] = '{2'd1, 24'h0,       64,  3, 24'h000000, 1'b0};
    vecs[15] = '{2'd1, 24'h0,       67,  3, 24'h000000, 1'b0};
    vecs[16] = '{2'd2, 24'h0,        0,  0, 24'h000000, 1'b1};
    vecs[17] = '{2'd2, 24'h0,       32,  0, 24'hFFFFFF, 1'b1};
    vecs[18] = '{2'd2, 24'h0,        0, 10, 24'h000000, 1'b1};
    vecs[19] = '{2'd2, 24'h0,       31, 31, 24'h000000, 1'b1};
    vecs[20] = '{2'd2, 24'h0,       10, 33, 24'hFFFFFF, 1'b1};
    vecs[21] = '{2'd2, 24'h0,       40, 33, 24'h000000, 1'b1};
    vecs[22] = '{2'd3, 24'h123456,   1,  1, 24'h123456, 1'b1};
    vecs[23] = '{2'd3, 24'h123456,  63, 35, 24'h123456, 1'b1};

    repeat (3) @(negedge clock);
    checkResetValues("reset");
    releaseAndCheck("release");

    // One full frame period, starting right at a frame_start pulse.
    fs_count = 0; fs_pos = 0; hs_low = 0; vs_low = 0;
    clk_high = 0; clk_rise = 0; blank_high = 0; syncn_high = 0;
    prev_clk = vga_clk;
    for (int i = 1; i <= FRAME_CLKS; i++) begin
      @(negedge clock);
      if (frame_start) begin
        fs_count++;
        fs_pos = i;
      end
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (vga_clk) clk_high++;
      if (vga_clk && !prev_clk) clk_rise++;
      if (blank) blank_high++;
      if (syncn) syncn_high++;
      prev_clk = vga_clk;
    end
    compare("timing.fs_count", 32'(fs_count), 32'd1);
    compare("timing.fs_period", 32'(fs_pos), 32'(FRAME_CLKS));
    compare("timing.hsync_low", 32'(hs_low), 32'(H_SYNC * V_TOTAL * CLK_DIV));
    compare("timing.vsync_low", 32'(vs_low), 32'(V_SYNC * H_TOTAL * CLK_DIV));
    compare("timing.vga_clk_high", 32'(clk_high), 32'(FRAME_CLKS / 2));
    compare("timing.vga_clk_rise", 32'(clk_rise), 32'(FRAME_CLKS / CLK_DIV));
    compare("timing.blank_high", 32'(blank_high), 32'(H_ACTIVE * V_ACTIVE * CLK_DIV));
    compare("timing.syncn_high", 32'(syncn_high), 32'd0);

    for (int i = 0; i < 24; i++) begin
      if (i == 0 || vecs[i].mode != vecs[i-1].mode || vecs[i].solid != vecs[i-1].solid)
        applyStimulus(vecs[i].mode, vecs[i].solid);
      checkOutput($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].rgb, vecs[i].blank);
    end

    // Solid colour changed mid-frame must wait for the next frame.
    checkOutput("solid.before", 10, 20, 24'h123456, 1'b1);
    solid_rgb_i = 24'hABCDEF;
    checkOutput("solid.same_line", 30, 20, 24'h123456, 1'b1);
    checkOutput("solid.later_line", 5, 30, 24'h123456, 1'b1);
    checkOutput("solid.next_origin", 0, 0, 24'hABCDEF, 1'b1);
    checkOutput("solid.next_pix", 1, 1, 24'hABCDEF, 1'b1);

    // Asynchronous reset in the middle of a frame.
    checkOutput("midrst.pre", 5, 20, 24'hABCDEF, 1'b1);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 checkResetValues("midrst");
    @(negedge clock);
    releaseAndCheck("midrst.release");
    checkOutput("midrst.first", 1, 0, 24'hABCDEF, 1'b1);
    checkOutput("midrst.next", 20, 2, 24'hABCDEF, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
